// File: rtl/i2s_rx_deser.sv
// ---------------------------------------------------------------------------
// i2s_rx_deser
//   Philips I2S receiver: deserializes MSB-first, one-BCLK-delayed stereo
//   frames from already-synchronized BCLK/LRCLK/SDATA levels in the system
//   clock domain. BCLK rising edges are found by comparing the synchronized
//   level with its one-cycle-delayed copy.
//
// Parameters
//   DATA_W : captured sample width, MSB-justified in the slot (1..SLOT_W-1)
//   SLOT_W : BCLK periods per channel half-frame
//
// Ports
//   clk          : system clock (at least 4x BCLK)
//   reset_n      : asynchronous active-low reset
//   bclk_s       : synchronized BCLK level
//   lrclk_s      : synchronized LRCLK level (0 = left, 1 = right)
//   sdata_s      : synchronized serial data level
//   left_out     : last complete left sample (two's complement)
//   right_out    : last complete right sample
//   sample_valid : one-cycle strobe when left_out/right_out update
//   frame_err    : one-cycle strobe on a half-frame length mismatch
//   locked       : high once aligned to an LRCLK transition
// ---------------------------------------------------------------------------
module i2s_rx_deser #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bclk_s,
    input  logic              lrclk_s,
    input  logic              sdata_s,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              locked
);

    // Counter must hold SLOT_W+1 so an overlong half is still distinguishable.
    localparam int CNT_W = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);

    logic              bclk_q;
    logic              ws_prev_q,   ws_prev_d;
    logic [CNT_W-1:0]  half_cnt_q,  half_cnt_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic              left_ok_q,   left_ok_d;
    logic [DATA_W-1:0] left_q,      left_d;
    logic [DATA_W-1:0] right_q,     right_d;
    logic              valid_q,     valid_d;
    logic              err_q,       err_d;
    logic              locked_q,    locked_d;
    logic              rise_s;

    assign rise_s       = bclk_s & ~bclk_q;
    assign left_out     = left_q;
    assign right_out    = right_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign locked       = locked_q;

    // Next-state logic: everything except bclk_q advances only on a BCLK rise.
    always_comb begin
        ws_prev_d   = ws_prev_q;
        half_cnt_d  = half_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        left_d      = left_q;
        right_d     = right_q;
        locked_d    = locked_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (rise_s) begin
            if (lrclk_s != ws_prev_q) begin
                // Transition rise: sdata here is the previous word's last
                // slot bit, so it is not captured.
                ws_prev_d  = lrclk_s;
                half_cnt_d = CNT_ONE;
                if (!locked_q) begin
                    // First transition only aligns; no completed half yet.
                    locked_d  = 1'b1;
                    left_ok_d = 1'b0;
                end else if (half_cnt_q == CNT_SLOT) begin
                    if (!ws_prev_q) begin
                        left_hold_d = shift_q;
                        left_ok_d   = 1'b1;
                    end else if (left_ok_q) begin
                        // Both channels publish together from a matched pair.
                        left_d    = left_hold_q;
                        right_d   = shift_q;
                        valid_d   = 1'b1;
                        left_ok_d = 1'b0;
                    end else begin
                        // Right half without a preceding good left: drop it.
                        left_ok_d = 1'b0;
                    end
                end else begin
                    err_d     = 1'b1;
                    left_ok_d = 1'b0;
                end
            end else begin
                // Slot positions 1..DATA_W carry the word, MSB first.
                if ((half_cnt_q != CNT_ZERO) && (half_cnt_q <= CNT_DATA)) begin
                    shift_d    = shift_q << 1;
                    shift_d[0] = sdata_s;
                end else begin
                    shift_d = shift_q;
                end
                if (half_cnt_q != CNT_MAX) begin
                    half_cnt_d = half_cnt_q + CNT_ONE;
                end else begin
                    half_cnt_d = CNT_MAX;
                end
            end
        end else begin
            half_cnt_d = half_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_q      <= 1'b0;
            ws_prev_q   <= 1'b0;
            half_cnt_q  <= CNT_ZERO;
            shift_q     <= {DATA_W{1'b0}};
            left_hold_q <= {DATA_W{1'b0}};
            left_ok_q   <= 1'b0;
            left_q      <= {DATA_W{1'b0}};
            right_q     <= {DATA_W{1'b0}};
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            bclk_q      <= bclk_s;
            ws_prev_q   <= ws_prev_d;
            half_cnt_q  <= half_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- Serial-to-parallel I2S receiver in the holosynth_audio path, directly downstream of the 2-flop input synchronizers.
- Consumes the already-synchronized BCLK, LRCLK and SDATA levels in the system clock domain and detects BCLK rising edges.
- Deserializes MSB-first, 1-BCLK-delayed (Philips I2S) stereo frames.
- Presents left/right sample pairs with a one-cycle valid strobe, and flags malformed frames.

Parameters:
- DATA_W, 24, captured sample width; MSB-justified within the slot; 1 ≤ DATA_W ≤ SLOT_W-1.
- SLOT_W, 32, BCLK periods per channel half-frame.

Ports:
- clk, input, 1, system clock; must be at least 4× BCLK frequency.
- reset_n, input, 1, asynchronous active-low reset.
- bclk_s, input, 1, synchronized BCLK level.
- lrclk_s, input, 1, synchronized LRCLK level; 0 = left, 1 = right.
- sdata_s, input, 1, synchronized serial data level.
- left_out, output, DATA_W, last complete left sample, two's complement.
- right_out, output, DATA_W, last complete right sample.
- sample_valid, output, 1, one-cycle strobe when left_out/right_out update.
- frame_err, output, 1, one-cycle strobe on a half-frame length mismatch.
- locked, output, 1, high once the block is aligned to an LRCLK transition.

Behaviour:
- **Reset:** reset_n low asynchronously clears all state and outputs. left_out=0, right_out=0, sample_valid=0, frame_err=0, locked=0, bclk_d=0, ws_prev=0, half_cnt=0, shift=0, left_hold=0, left_ok=0.
- **Rise event:** rise = bclk_s & ~bclk_d, combinational. bclk_d <= bclk_s every cycle. All state below updates only on a clk edge where rise=1. Non-rise cycles hold state, and sample_valid/frame_err return to 0.
- **Transition rise** (lrclk_s != ws_prev):
  - ws_prev <= lrclk_s.
  - half_cnt <= 1.
  - This rise's sdata_s is the previous word's last slot bit and is not captured.
  - If locked=0: locked <= 1, left_ok <= 0, no outputs.
  - If locked=1 and half_cnt == SLOT_W: the completed half is good.
    - Completed half was left (ws_prev=0): left_hold <= shift, left_ok <= 1.
    - Completed half was right (ws_prev=1) and left_ok=1: left_out <= left_hold, right_out <= shift, sample_valid <= 1, left_ok <= 0.
    - Completed half was right with left_ok=0: the right word is discarded silently.
  - If locked=1 and half_cnt != SLOT_W: frame_err <= 1, left_ok <= 0, the word is discarded, and locked stays 1.
- **Non-transition rise:**
  - If 1 ≤ half_cnt ≤ DATA_W: shift <= {shift[DATA_W-2:0], sdata_s}.
  - half_cnt increments, saturating at SLOT_W+1 so an overlong half is still detected.
- **Word alignment:** the first non-transition rise after a transition carries the MSB. Bits beyond DATA_W in the slot are ignored.
- **Latency and update rules:**
  - Outputs change on the clk edge where the transition rise of the left→... right→left boundary is processed.
  - sample_valid is high for exactly one clk cycle per stereo frame.
  - left_out and right_out always update together, never one channel alone.
- **Simultaneous events:** a frame error and lock acquisition cannot coincide. When locked=0, no error is reported.
- **Reset mid-frame:** the next transition is used only to lock. The first sample_valid requires a full left half followed by a full right half.
- **No BCLK:** all state holds indefinitely. No timeout.

Test Plan:
- **Basic capture:** DATA_W=24, SLOT_W=32, clk = 8× BCLK. After reset, send 3 frames, left=0x123456, right=0xFEDCBA, LSB-padded with zeros. Required: locked=1 after the first LRCLK edge. sample_valid pulses once per frame, starting with the first complete L+R pair. left_out=0x123456 and right_out=0xFEDCBA, updating in the same cycle. frame_err stays 0.
- **Reset values:** assert reset_n low mid-word. Required: all outputs are 0 immediately, without waiting for a clk edge. After release, the first valid sample_valid appears only after a full left+right pair following the lock edge.
- **Short half:** left half of 31 BCLKs. Required: frame_err pulses one cycle at the left→right transition. No sample_valid for that frame. The next well-formed frame produces correct outputs.
- **Long half:** right half of 40 BCLKs. Required: frame_err pulses one cycle. left_out/right_out keep their previous values.
- **Partial first frame:** start the stream mid-right-half. Required: no sample_valid until a complete left then right half has been received. The first pulse carries exactly those values.
- **Sign and extremes:** left=0x800000, right=0x7FFFFF, then both 0x000000. Required: outputs match bit-exactly; the MSB is taken from the second BCLK rise after the LRCLK change.
